instruction_fetch_controller: RTL and testbench
===============================================

# instruction_fetch_controller

Sequences the single read port of the instruction memory. It owns the program counter and fetches one word per cycle into a 2-entry fetch queue, which feeds decode over a valid/ready handshake. It also shares the port with a debug/monitor read requester. It sits between the instruction memory and the pipeline's IF/ID stage, and handles branch/jump redirects, flushes and a halt-on-sentinel condition.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.
- HALT_WORD, 32'h0000_000C, instruction encoding that stops fetching.

Ports:
- Clk  in  1  system clock, single clock domain.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  pulse; leaves IDLE and begins fetching.
- IM_Address  out  32  byte address to instruction memory. Bits [1:0] are always 0.
- IM_Instruction  in  32  memory read data, combinational from IM_Address in the same cycle.
- Out_Valid  out  1  queue head valid.
- Out_Ready  in  1  decode accepts head this cycle.
- Out_Instruction  out  32  head instruction.
- Out_PC  out  32  byte address of head instruction.
- Redirect_Valid  in  1  branch/jump taken; flush and retarget.
- Redirect_Target  in  32  new PC. Bits [1:0] are ignored and forced to 0.
- Dbg_Req  in  1  debug read request, held until Dbg_Ack.
- Dbg_Addr  in  32  debug byte address. Bits [1:0] are forced to 0.
- Dbg_Ack  out  1  one-cycle pulse; Dbg_Data is valid with it.
- Dbg_Data  out  32  registered debug read data.
- Halted  out  1  high in HALTED state.

## Operation
- FSM states: IDLE, RUN, HALTED. Reset state is IDLE.
- IDLE to RUN on Start.
- RUN to HALTED when a word equal to HALT_WORD is written into the queue. The halt word itself is enqueued and delivered to decode.
- HALTED to RUN on Redirect_Valid.
- Rst returns to IDLE from any state.
- Port arbitration, evaluated each cycle:
  - Debug is granted when Dbg_Req=1 and debug was not granted in the previous cycle. This alternation bounds fetch starvation to 1 cycle in 2.
  - Otherwise fetch is granted.
  - In IDLE or HALTED, debug is granted whenever Dbg_Req=1.
- IM_Address is Dbg_Addr when debug is granted, else PC.
- A fetch fires when all hold: state is RUN, fetch has the grant, Redirect_Valid=0, and the queue has space. Space means count<2, or count=2 with a pop this cycle.
- On a fetch: enqueue {PC, IM_Instruction}, then PC <= PC+4. PC wraps modulo 2^32.
- A pop occurs when Out_Valid and Out_Ready are both high.
- Push and pop in the same cycle: count unchanged, FIFO order preserved.
- Redirect_Valid has top priority:
  - Queue count goes to 0 and any same-cycle push/pop is discarded.
  - PC <= {Redirect_Target[31:2], 2'b00}.
  - No fetch occurs in the redirect cycle. A debug grant in that cycle still completes.
- Redirect in IDLE: PC is loaded, state stays IDLE.
- Debug grant: Dbg_Data <= IM_Instruction and Dbg_Ack <= 1 on the next edge. Dbg_Req must drop on the cycle Dbg_Ack is seen, or a new read starts.

## Timing
- Reset values:
  - PC=RESET_PC, queue count=0, state=IDLE.
  - Out_Valid=0, Out_Instruction=0, Out_PC=0 (when empty, outputs are 0).
  - Dbg_Ack=0, Dbg_Data=0, Halted=0.
  - IM_Address=RESET_PC when Dbg_Req=0.
- Fetch latency: a word fetched at edge t is visible on Out_* after edge t+1.
- Sustained throughput is 1 instr/cycle with Out_Ready=1 and no debug traffic.
- Debug latency: 1 cycle from grant to Dbg_Ack.
- Redirect: Out_Valid=0 the cycle after the redirect. The first target instruction is valid 2 cycles after the redirect.
- Out_Ready=0 with the queue full: PC holds, Out_* stable.
- Rst mid-operation overrides all other inputs, including a simultaneous Start or Redirect_Valid.

## Structure
- Shared package `fetch_pkg`:
  - fetch_state_t enum (IDLE/RUN/HALTED).
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
  - Default RESET_PC and HALT_WORD constants.
- Sub-module `fetch_queue`: 2-entry FIFO of fetch_entry_t with push/pop/flush and count. Flush has priority over push/pop.
- Arbiter, PC and FSM live in the top module.

## Test plan
- Reset, Start, memory[i]=i*4, Out_Ready=1 → Out_PC/Out_Instruction = 0/0, 4/4, 8/8, … on consecutive cycles, first valid 2 cycles after Start.
- Out_Ready=0 for 5 cycles after 2 fetches → count=2, IM_Address holds 0x8, head stays 0/0. Release → 4/4 then 8/8 with no gaps.
- Redirect_Target=0x41 while queue holds 2 entries → Out_Valid=0 next cycle, then Out_PC=0x40, 0x44; stale entries never appear.
- Dbg_Req held, Dbg_Addr=0x10, in RUN → Dbg_Ack pulses with Dbg_Data=0x10; fetch and debug alternate on the port, and fetch advances every other cycle.
- memory[3]=HALT_WORD → entries 0x0–0xC delivered, Halted=1, no fetch beyond 0xC. Redirect to 0x20 → resumes with 0x20.
- Assert Rst during RUN with queue full → next cycle Out_Valid=0, IDLE, PC=RESET_PC, Dbg_Ack=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_HALT_WORD = 32'h0000_000C;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs; flush wins over push/pop.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t ent0, ent1;
  logic         do_push, do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count < 2'd2) || do_pop);
  // Empty queue presents zeros rather than stale data.
  assign head    = (count != 2'd0) ? ent0 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= din;
          else               ent1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) ent0 <= din;
          else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_controller.sv
// Owns the PC, arbitrates the single imem read port between fetch and debug,
// and feeds a 2-entry queue towards decode.
module instruction_fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  output logic [31:0] IM_Address,
  input  logic [31:0] IM_Instruction,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Out_Instruction,
  output logic [31:0] Out_PC,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  input  logic        Dbg_Req,
  input  logic [31:0] Dbg_Addr,
  output logic        Dbg_Ack,
  output logic [31:0] Dbg_Data,
  output logic        Halted
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         dbg_last;
  logic         dbg_grant;
  logic         pop;
  logic         fetch;
  logic         space;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t din;

  // Outside RUN nobody competes for the port; in RUN debug yields every other cycle.
  assign dbg_grant  = Dbg_Req && ((state != RUN) || !dbg_last);
  assign IM_Address = dbg_grant ? {Dbg_Addr[31:2], 2'b00} : pc;

  assign pop   = Out_Valid && Out_Ready;
  assign space = (count < 2'd2) || pop;
  assign fetch = (state == RUN) && !dbg_grant && !Redirect_Valid && space;
  assign din   = '{pc: pc, instr: IM_Instruction};

  fetch_queue u_queue (
    .clk   (Clk),
    .rst   (Rst),
    .push  (fetch),
    .pop   (pop),
    .flush (Redirect_Valid),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign Out_Valid       = (count != 2'd0);
  assign Out_PC          = head.pc;
  assign Out_Instruction = head.instr;
  assign Halted          = (state == HALTED);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      dbg_last <= 1'b0;
      Dbg_Ack  <= 1'b0;
      Dbg_Data <= '0;
    end else begin
      dbg_last <= dbg_grant;
      Dbg_Ack  <= dbg_grant;
      if (dbg_grant) Dbg_Data <= IM_Instruction;

      if (Redirect_Valid) pc <= {Redirect_Target[31:2], 2'b00};
      else if (fetch)     pc <= pc + 32'd4;

      case (state)
        IDLE:    if (Start) state <= RUN;
        RUN:     if (fetch && (IM_Instruction == HALT_WORD)) state <= HALTED;
        HALTED:  if (Redirect_Valid) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed pins plus randomized traffic against a queue-based reference model.
module tb_instruction_fetch_controller;

  localparam logic [31:0] HALT = 32'h0000_000C;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0, Start = 1'b0, Out_Ready = 1'b0;
  logic        Redirect_Valid = 1'b0, Dbg_Req = 1'b0;
  logic [31:0] Redirect_Target = '0, Dbg_Addr = '0;
  logic [31:0] IM_Address, IM_Instruction, Out_Instruction, Out_PC, Dbg_Data;
  logic        Out_Valid, Dbg_Ack, Halted;

  logic [31:0] mem [0:255];
  assign IM_Instruction = mem[IM_Address[9:2]];

  always #5 Clk = ~Clk;

  instruction_fetch_controller dut (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .IM_Address(IM_Address), .IM_Instruction(IM_Instruction),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Instruction(Out_Instruction), .Out_PC(Out_PC),
    .Redirect_Valid(Redirect_Valid), .Redirect_Target(Redirect_Target),
    .Dbg_Req(Dbg_Req), .Dbg_Addr(Dbg_Addr),
    .Dbg_Ack(Dbg_Ack), .Dbg_Data(Dbg_Data), .Halted(Halted)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  // Reference model: 0=idle, 1=run, 2=halted
  int          mst = 0;
  logic [31:0] mpc = '0;
  ent_t        q[$];
  bit          m_prev = 0, m_ack = 0, synced = 0;
  logic [31:0] m_data = '0;
  int          errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit          grant;
    logic [31:0] addr;
    grant = Dbg_Req && (mst != 1 || !m_prev);
    addr  = grant ? {Dbg_Addr[31:2], 2'b00} : mpc;
    chk("im_address", IM_Address, addr);
    chk("out_valid", {31'b0, Out_Valid}, {31'b0, q.size() > 0});
    chk("out_pc", Out_PC, (q.size() > 0) ? q[0].pc : 32'h0);
    chk("out_instr", Out_Instruction, (q.size() > 0) ? q[0].instr : 32'h0);
    chk("halted", {31'b0, Halted}, {31'b0, mst == 2});
    chk("dbg_ack", {31'b0, Dbg_Ack}, {31'b0, m_ack});
    chk("dbg_data", Dbg_Data, m_data);
  endtask

  task automatic model_update();
    bit          grant, pop, fetch;
    logic [31:0] addr, rd;
    grant = Dbg_Req && (mst != 1 || !m_prev);
    addr  = grant ? {Dbg_Addr[31:2], 2'b00} : mpc;
    rd    = mem[addr[9:2]];
    pop   = (q.size() > 0) && Out_Ready;
    if (Rst) begin
      mst = 0; mpc = '0; q.delete(); m_prev = 0; m_ack = 0; m_data = '0; synced = 1;
      return;
    end
    m_prev = grant;
    m_ack  = grant;
    if (grant) m_data = rd;
    if (Redirect_Valid) begin
      q.delete();
      mpc = {Redirect_Target[31:2], 2'b00};
      if (mst == 2) mst = 1;
      else if (mst == 0 && Start) mst = 1;
    end else begin
      fetch = (mst == 1) && !grant && (q.size() < 2 || pop);
      if (pop) void'(q.pop_front());
      if (fetch) begin
        q.push_back('{mpc, rd});
        mpc += 32'd4;
        if (rd == HALT) mst = 2;
      end
      if (mst == 0 && Start) mst = 1;
    end
  endtask

  // Inputs are set at a falling edge; outputs checked 1ns later, then the model advances.
  task automatic step();
    #1;
    if (synced) compare();
    model_update();
    @(negedge Clk);
  endtask

  task automatic head_is(input string name, input logic [31:0] v);
    chk({name, "_valid"}, {31'b0, Out_Valid}, 32'd1);
    chk({name, "_pc"}, Out_PC, v);
    chk({name, "_instr"}, Out_Instruction, v);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i * 4;

    Rst = 1'b1; step(); step(); Rst = 1'b0;
    chk("rst_valid", {31'b0, Out_Valid}, 32'd0);
    chk("rst_pc", Out_PC, 32'd0);
    chk("rst_instr", Out_Instruction, 32'd0);
    chk("rst_halted", {31'b0, Halted}, 32'd0);
    chk("rst_ack", {31'b0, Dbg_Ack}, 32'd0);
    chk("rst_dbgdata", Dbg_Data, 32'd0);
    chk("rst_addr", IM_Address, 32'd0);

    // Stream from 0; word 3 (0xC) is the halt encoding
    Start = 1'b1; Out_Ready = 1'b1; step(); Start = 1'b0;
    chk("lat_valid", {31'b0, Out_Valid}, 32'd0);
    step(); head_is("s0", 32'h0);
    step(); head_is("s4", 32'h4);
    step(); head_is("s8", 32'h8);
    step(); head_is("sC", 32'hC);
    chk("halt_set", {31'b0, Halted}, 32'd1);
    step();
    chk("halt_empty", {31'b0, Out_Valid}, 32'd0);
    chk("halt_pc", IM_Address, 32'h10);
    step();
    chk("halt_nofetch", {31'b0, Out_Valid}, 32'd0);

    // Resume via redirect, then stall with full queue
    Redirect_Valid = 1'b1; Redirect_Target = 32'h21; Out_Ready = 1'b0; step();
    Redirect_Valid = 1'b0;
    chk("resume_gap", {31'b0, Out_Valid}, 32'd0);
    chk("resume_run", {31'b0, Halted}, 32'd0);
    step(); head_is("r20", 32'h20);
    step();
    repeat (5) begin
      step();
      head_is("stall", 32'h20);
      chk("stall_addr", IM_Address, 32'h28);
    end
    Out_Ready = 1'b1;
    step(); head_is("rel24", 32'h24);
    step(); head_is("rel28", 32'h28);

    // Redirect with two entries queued
    Redirect_Valid = 1'b1; Redirect_Target = 32'h41; step(); Redirect_Valid = 1'b0;
    chk("redir_gap", {31'b0, Out_Valid}, 32'd0);
    step(); head_is("t40", 32'h40);
    step(); head_is("t44", 32'h44);

    // Debug reads interleaved with fetch
    Dbg_Req = 1'b1; Dbg_Addr = 32'h13; #1;
    chk("dbg_addr", IM_Address, 32'h10);
    step();
    chk("dbg_ack1", {31'b0, Dbg_Ack}, 32'd1);
    chk("dbg_data1", Dbg_Data, 32'h10);
    step(); chk("dbg_ack_gap", {31'b0, Dbg_Ack}, 32'd0);
    step(); chk("dbg_ack2", {31'b0, Dbg_Ack}, 32'd1);
    Dbg_Req = 1'b0; step(); step();

    // Reset overrides everything with a full queue
    Out_Ready = 1'b0; step(); step(); step();
    Dbg_Req = 1'b1; Rst = 1'b1; Start = 1'b1; Redirect_Valid = 1'b1; Redirect_Target = 32'h80;
    step();
    Rst = 1'b0; Start = 1'b0; Redirect_Valid = 1'b0; Dbg_Req = 1'b0; #1;
    chk("mrst_valid", {31'b0, Out_Valid}, 32'd0);
    chk("mrst_ack", {31'b0, Dbg_Ack}, 32'd0);
    chk("mrst_addr", IM_Address, 32'd0);
    step();
    chk("mrst_idle", {31'b0, Out_Valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? HALT : $urandom;
    for (int n = 0; n < 3000; n++) begin
      Rst             = ($urandom_range(0, 99) == 0);
      Start           = ($urandom_range(0, 4) == 0);
      Out_Ready       = ($urandom_range(0, 9) < 7);
      Redirect_Valid  = ($urandom_range(0, 11) == 0);
      Redirect_Target = $urandom;
      Dbg_Req         = ($urandom_range(0, 9) < 3);
      Dbg_Addr        = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
